// File: rtl/load_store_unit_if.sv
// Word-wide variable-latency data-memory bus between the load/store unit and memory.
// The master drives request, direction, address, byte enables and write data; the slave answers with ack and read data.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: formats stores onto the word bus, extends load results,
// and holds the datapath stalled until the bus transaction completes or times out.
//
// state | meaning
// IDLE  | watch for a load/store; fault or launch a bus request
// REQ   | bus_req high with latched address/data; wait for ack or timeout
// RESP  | transaction done, stall released, instruction commits
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              fault,
  output logic              bus_err,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          access, is_store, unsupported, misaligned, fault_c, start;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic [1:0]    alo_q;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   fmt_c;

  assign access   = mem_read | mem_write;
  assign is_store = mem_write;

  always_comb begin
    if (is_store)
      unsupported = !(funct3 inside {3'b000, 3'b001, 3'b010});
    else
      unsupported = funct3 inside {3'b011, 3'b110, 3'b111};
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    fault_c    = unsupported | misaligned;
  end

  // Byte enables and lane replication depend only on size, so loads share them.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  always_comb begin
    rbyte = bus.bus_rdata[7:0];
    case (alo_q)
      2'd0:    rbyte = bus.bus_rdata[7:0];
      2'd1:    rbyte = bus.bus_rdata[15:8];
      2'd2:    rbyte = bus.bus_rdata[23:16];
      default: rbyte = bus.bus_rdata[31:24];
    endcase
    rhalf = alo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q)
      3'b000:  fmt_c = {{24{rbyte[7]}}, rbyte};
      3'b001:  fmt_c = {{16{rhalf[15]}}, rhalf};
      3'b100:  fmt_c = {24'd0, rbyte};
      3'b101:  fmt_c = {16'd0, rhalf};
      default: fmt_c = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    fault     = 1'b0;
    bus_err   = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (fault_c) begin
            fault = 1'b1;
          end else begin
            stall     = 1'b1;
            start     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          bus_err   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      f3_q      <= '0;
      alo_q     <= '0;
      cnt       <= '0;
      load_data <= '0;
    end else if (start) begin
      we_q    <= is_store;
      addr_q  <= {addr[31:2], 2'b00};
      wdata_q <= wdata_c;
      be_q    <= be_c;
      f3_q    <= funct3;
      alo_q   <= addr[1:0];
      cnt     <= '0;
    end else if (state == REQ) begin
      if (bus.bus_ack) begin
        if (!we_q) load_data <= fmt_c;
      end else if (bus_err) begin
        load_data <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.bus_req   = (state == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage sitting directly downstream of the single-cycle datapath's ALU. It consumes the effective address (ALU result) and store data (rs2), drives a variable-latency word-wide memory bus with byte enables, and returns the sign/zero-extended load result to the register-file writeback mux. It stalls the datapath (PC and register writes frozen) until the bus transaction completes, and flags misaligned or unsupported accesses.

## Interface
- TIMEOUT, 64: maximum REQ cycles without bus_ack before bus error.
- rclk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_read  in  1  load instruction in current cycle (from control).
- mem_write  in  1  store instruction in current cycle (from control).
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  effective byte address (ALU result).
- store_data  in  32  store data (rs2 read value).
- load_data  out  32  formatted load result to writeback mux.
- stall  out  1  freeze PC and register-file write this cycle.
- fault  out  1  misaligned or unsupported access, same-cycle.
- bus_err  out  1  one-cycle pulse on bus timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  32  word address, {addr[31:2], 2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  transaction complete.

## Operation
- FSM states IDLE, REQ, RESP.
- access = mem_read | mem_write; mem_write wins if both high (treated as store).
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. Unsupported: loads with funct3 ∈ {011,110,111}; stores with funct3 ≠ 000/001/010. Either → fault.
- IDLE: if access & fault: fault=1 (combinational), stall=0, no bus activity, state stays IDLE. If access & !fault: stall=1 (combinational), latch we, bus_addr, bus_be, bus_wdata, funct3, addr[1:0]; clear timeout counter; → REQ.
- REQ: bus_req=1, bus_* from latched registers, stall=1. On bus_ack: for loads, register formatted bus_rdata into load_data; → RESP. Else counter increments; when counter reaches TIMEOUT-1 without ack: bus_err=1 for that cycle, load_data ← 0, → RESP.
- RESP: stall=0, bus_req=0; datapath commits the instruction on this edge; → IDLE unconditionally. Next IDLE sees the following instruction, so no retrigger.
- Store formatting: B: be = 1<<addr[1:0], wdata = {4{sd[7:0]}}; H: be = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}; W: be = 1111, wdata = sd.
- Load formatting: select byte addr[1:0] or half addr[1]; B/H sign-extend, BU/HU zero-extend, W passthrough.
- load_data holds its value except on load completion or timeout; stores do not modify it.
- bus_ack outside REQ ignored.

## Timing
- Reset values: state IDLE, load_data 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, bus_err 0, counter 0; stall and fault follow IDLE combinational logic.
- rst sampled high in any state → IDLE at that edge; in-flight transaction abandoned, bus_req low from the next cycle.
- Minimum access: 3 cycles (T0 IDLE detect, T1 REQ with ack, T2 RESP commit); each cycle of ack delay adds one.
- Timeout: bus_err on the TIMEOUT-th REQ cycle; RESP follows.
- bus_* outputs stable for the entire REQ state.
- Non-memory instructions: stall=0, single-cycle, zero added latency.

## Test plan
- LW addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> stall high T0-T1, bus_be 1111, bus_addr 0x100, load_data 0xDEADBEEF in T2, stall low T2.
- LB addr 0x103, rdata 0x80FF0011 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, store_data 0x000000AB -> bus_we 1, bus_be 0010, bus_wdata 0xABABABAB, bus_addr 0x200; load_data unchanged.
- LW addr 0x102 -> fault 1, stall 0, bus_req never asserted; funct3 011 store -> fault 1.
- LW with ack withheld -> bus_err pulse on 64th REQ cycle, load_data 0, RESP next cycle, then IDLE.
- rst asserted during REQ with ack delayed 5 cycles -> IDLE next cycle, bus_req 0, load_data 0, late ack ignored.
